// File: rtl/mult_share_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
// Tag widths are sized for the largest supported requester count.
package mult_share_pkg;

  localparam int DATA_W  = 32;
  localparam int MAX_REQ = 8;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

  localparam int ID_W = clog2(MAX_REQ);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mult_share_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant searched from ptr+1,
// pointer moves to the granted requester whenever update is high.
module mult_share_rr_arb
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] eligible,
  input  logic               update,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic [ID_W-1:0] ptr_reg;
  logic            found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && eligible[i] && (i == (int'(ptr_reg) + off) % NUM_REQ)) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          grant_id = ID_W'(i);
        end
      end
    end
  end

  // Reset value makes requester 0 the first winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= ID_W'(NUM_REQ - 1);
    end else if (update) begin
      ptr_reg <= grant_id;
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one external pipelined multiplier among NUM_REQ requesters: issues one
// op per cycle round-robin, tracks ownership with a tag pipe, routes results back.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 1,
  parameter int CNT_W       = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [DATA_W*NUM_REQ-1:0] req_src1,
  input  logic [DATA_W*NUM_REQ-1:0] req_src2,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [DATA_W-1:0]         mul_src1,
  output logic [DATA_W-1:0]         mul_src2,
  output logic                      mul_clr,
  input  logic [DATA_W-1:0]         mul_result,
  output logic                      busy,
  output logic [CNT_W-1:0]          ops_issued
);

  logic [NUM_REQ-1:0] pending_reg;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] exit_onehot;
  logic [ID_W-1:0]    grant_id;
  logic               any_grant;
  logic [DATA_W-1:0]  sel_src1;
  logic [DATA_W-1:0]  sel_src2;
  tag_t               tag_pipe_reg [MUL_LATENCY+1];
  tag_t               tag_exit;

  // Nothing is accepted while reset is held, so in-flight state stays empty.
  assign eligible  = reset ? '0 : (req_valid & ~pending_reg);
  assign any_grant = |grant;
  assign req_ready = grant;
  assign mul_clr   = reset;
  assign busy      = |pending_reg;
  assign tag_exit  = tag_pipe_reg[MUL_LATENCY];

  mult_share_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arb (
    .clk      (clk),
    .reset    (reset),
    .eligible (eligible),
    .update   (any_grant),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always_comb begin
    sel_src1 = '0;
    sel_src2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_src1 = sel_src1 | req_src1[DATA_W*i +: DATA_W];
        sel_src2 = sel_src2 | req_src2[DATA_W*i +: DATA_W];
      end
    end
  end

  // Ownership tag travels alongside the op through the cell's pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_pipe_reg[0] <= '0;
    end else begin
      tag_pipe_reg[0] <= '{vld: any_grant, id: grant_id};
    end
  end

  generate
    for (genvar gi = 1; gi <= MUL_LATENCY; gi++) begin : g_tag_stage
      always_ff @(posedge clk) begin
        if (reset) begin
          tag_pipe_reg[gi] <= '0;
        end else begin
          tag_pipe_reg[gi] <= tag_pipe_reg[gi-1];
        end
      end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_exit_dec
      assign exit_onehot[gi] = tag_exit.vld && (tag_exit.id == ID_W'(gi));
    end
  endgenerate

  // A retiring requester and a newly granted one are never the same, so
  // clear and set of pending can safely share an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      mul_src1    <= '0;
      mul_src2    <= '0;
      ops_issued  <= '0;
    end else begin
      rsp_valid   <= exit_onehot;
      pending_reg <= (pending_reg & ~exit_onehot) | grant;
      if (tag_exit.vld) begin
        rsp_data <= mul_result;
      end
      if (any_grant) begin
        mul_src1   <= sel_src1;
        mul_src2   <= sel_src2;
        ops_issued <= ops_issued + CNT_W'(1);
      end
    end
  end

endmodule
